// File: rtl/data_bus_system.sv
// data_bus_system: CPU data-side memory. A word RAM in the low half of the
// 16-bit byte address space plus a small I/O page at 0x8000: a GPIO output
// register, a free-running cycle counter and a byte transmit FIFO drained
// over a stream port. Reads are combinational and side-effect free; writes
// commit on the rising clock edge while i_rw is high.
module data_bus_system #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_address,
    input  logic        i_rw,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic [31:0] o_gpio,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Word addresses (i_address[15:2]) of the I/O registers.
    localparam logic [13:0] WA_GPIO   = 14'h2000;
    localparam logic [13:0] WA_CYCLE  = 14'h2001;
    localparam logic [13:0] WA_TXDATA = 14'h2002;
    localparam logic [13:0] WA_TXSTAT = 14'h2003;

    logic [13:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          unused_byte_lane;
    logic          sel_ram;
    logic          wr_ram, wr_gpio, wr_cycle, wr_txdata, wr_txstat;

    // The bus is word-addressed; the byte-lane bits carry no meaning here.
    assign word_addr        = i_address[15:2];
    assign unused_byte_lane = ^i_address[1:0];
    assign ram_idx          = i_address[AW+1:2];
    assign sel_ram          = ~i_address[15];

    assign wr_ram    = i_rw & sel_ram;
    assign wr_gpio   = i_rw & (word_addr == WA_GPIO);
    assign wr_cycle  = i_rw & (word_addr == WA_CYCLE);
    assign wr_txdata = i_rw & (word_addr == WA_TXDATA);
    assign wr_txstat = i_rw & (word_addr == WA_TXSTAT);

    // ------------------------------------------------------------------
    // Word RAM: asynchronous read, synchronous write, contents not reset.
    // Address bits above the RAM size alias onto the same words.
    // ------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    // Commit a RAM write at the clock edge.
    always_ff @(posedge i_clk) begin
        if (wr_ram) ram[ram_idx] <= i_data;
    end

    // ------------------------------------------------------------------
    // GPIO and cycle counter
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;

    // GPIO register holds the last value written to it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)   o_gpio <= '0;
        else if (wr_gpio) o_gpio <= i_data;
    end

    // Counter advances every cycle; a write replaces the increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)    cycle_cnt <= '0;
        else if (wr_cycle) cycle_cnt <= i_data;
        else               cycle_cnt <= cycle_cnt + 32'd1;
    end

    // ------------------------------------------------------------------
    // TX FIFO. Stream handshake: a byte transfers on a rising edge where
    // o_tx_valid and i_tx_ready are both high; while o_tx_valid is high and
    // the byte is not yet taken, o_tx_valid and o_tx_data stay unchanged.
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_ovf;
    logic          tx_empty, tx_full, tx_pop, tx_push, tx_drop;
    logic [3:0]    tx_count4;

    assign tx_empty  = (tx_count == '0);
    assign tx_full   = (tx_count == CW'(FIFO_DEPTH));
    assign tx_pop    = o_tx_valid & i_tx_ready;
    // A push into a full FIFO is only safe when a pop frees a slot this edge.
    assign tx_push   = wr_txdata & (~tx_full | tx_pop);
    assign tx_drop   = wr_txdata & tx_full & ~tx_pop;
    assign tx_count4 = 4'(tx_count);

    assign o_tx_valid = ~tx_empty;
    assign o_tx_data  = tx_empty ? 8'h00 : tx_mem[rd_ptr];

    // Store pushed bytes; storage needs no reset since empty masks the head.
    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[wr_ptr] <= i_data[7:0];
    end

    // Pointer, count and sticky overflow bookkeeping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tx_count <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + PW'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (tx_drop)                      tx_ovf <= 1'b1;
            else if (wr_txstat && i_data[2])  tx_ovf <= 1'b0;
        end
    end

    // Read mux: pure function of the address and current state.
    always_comb begin
        o_data = '0;
        if (sel_ram) begin
            o_data = ram[ram_idx];
        end else begin
            case (word_addr)
                WA_GPIO:   o_data = o_gpio;
                WA_CYCLE:  o_data = cycle_cnt;
                WA_TXSTAT: o_data = {24'b0, 1'b0, tx_count4, tx_ovf, tx_full, tx_empty};
                default:   o_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_system.sv
// Bench for data_bus_system: directed test-plan sequences with literal
// expectations, then randomized bus/sink traffic, all cross-checked every
// cycle against a behavioural model of the memory map and TX queue.
module tb_data_bus_system;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [15:0] i_address = 16'h8004;
    logic        i_rw = 1'b0;
    logic [31:0] i_data = '0;
    logic [31:0] o_data;
    logic [31:0] o_gpio;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    data_bus_system #(.RAM_WORDS(1024), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_address  (i_address),
        .i_rw       (i_rw),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_gpio     (o_gpio),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [int];
    logic [31:0] m_gpio = '0;
    logic [31:0] m_cycle = '0;
    bit          m_ovf = 1'b0;
    logic [7:0]  exp_q[$];

    function automatic void model_read(input logic [15:0] a, output logic [31:0] v,
                                       output bit known);
        int idx;
        known = 1'b1;
        v = '0;
        if (a < 16'h8000) begin
            idx = int'(a[11:2]);
            if (m_ram.exists(idx)) v = m_ram[idx];
            else known = 1'b0;
        end else begin
            case (a & 16'hFFFC)
                16'h8000: v = m_gpio;
                16'h8004: v = m_cycle;
                16'h800C: begin
                    v = 32'(exp_q.size()) << 3;
                    if (m_ovf) v = v | 32'h4;
                    if (exp_q.size() == DEPTH) v = v | 32'h2;
                    if (exp_q.size() == 0) v = v | 32'h1;
                end
                default: v = '0;
            endcase
        end
    endfunction

    // Apply one clock edge of bus and sink activity to the model.
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_gpio  = '0;
            m_cycle = '0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            bit was_full, pop, cyc_wr;
            logic [7:0] drained;
            was_full = (exp_q.size() == DEPTH);
            pop      = (exp_q.size() > 0) && i_tx_ready;
            cyc_wr   = 1'b0;
            if (pop) drained = exp_q.pop_front();
            if (i_rw) begin
                if (i_address < 16'h8000) m_ram[int'(i_address[11:2])] = i_data;
                else case (i_address & 16'hFFFC)
                    16'h8000: m_gpio = i_data;
                    16'h8004: cyc_wr = 1'b1;
                    16'h8008: if (was_full && !pop) m_ovf = 1'b1;
                              else exp_q.push_back(i_data[7:0]);
                    16'h800C: if (i_data[2]) m_ovf = 1'b0;
                    default: ;
                endcase
            end
            m_cycle = cyc_wr ? i_data : m_cycle + 32'd1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge i_clk) begin
        logic [31:0] v;
        bit known;
        check("gpio", o_gpio, m_gpio);
        check("tx_valid", 32'(o_tx_valid), 32'(exp_q.size() > 0));
        check("tx_data", 32'(o_tx_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
        model_read(i_address, v, known);
        if (known) check("o_data", o_data, v);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [15:0] a, input logic [31:0] d);
        i_address = a;
        i_rw      = 1'b1;
        i_data    = d;
        @(posedge i_clk); #1;
        i_rw      = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [15:0] a, input logic [31:0] exp);
        i_address = a;
        i_rw      = 1'b0;
        #1;
        check(name, o_data, exp);
        @(posedge i_clk); #1;
    endtask

    task automatic expect_stream(input string name, input logic [7:0] b);
        check({name, "_valid"}, 32'(o_tx_valid), 32'h1);
        check({name, "_byte"}, 32'(o_tx_data), 32'(b));
        @(posedge i_clk); #1;
    endtask

    function automatic logic [15:0] pick_addr();
        logic [31:0] r;
        logic [15:0] a;
        r = $urandom;
        case ($urandom_range(0, 11))
            0, 1, 2: a = {1'b0, r[14:12], 6'b0, r[5:0]};
            3:       a = 16'h8000;
            4:       a = 16'h8004;
            5, 6, 7: a = 16'h8008;
            8, 9:    a = 16'h800C;
            10:      a = 16'h8010;
            default: a = r[20] ? 16'h9000 : 16'hFFFC;
        endcase
        if (a >= 16'h8000) a = a | {14'b0, r[17:16]};
        return a;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int pct;
        // Reset values while reset is held.
        #2;
        check("rst_gpio", o_gpio, 32'h0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'h0);
        check("rst_tx_data", 32'(o_tx_data), 32'h0);
        check("rst_cycle", o_data, 32'h0);
        #10 i_reset_n = 1'b1;

        // Counter after reset: 0, 1, 2.
        check_read("cycle_0", 16'h8004, 32'd0);
        check_read("cycle_1", 16'h8004, 32'd1);
        check_read("cycle_2", 16'h8004, 32'd2);

        // RAM write, byte-offset read, alias read.
        drive(16'h0010, 32'hDEADBEEF);
        check_read("ram_rd", 16'h0010, 32'hDEADBEEF);
        check_read("ram_rd_off3", 16'h0013, 32'hDEADBEEF);
        check_read("ram_alias", 16'h1010, 32'hDEADBEEF);

        // GPIO and unmapped space.
        drive(16'h8000, 32'h12345678);
        check("gpio_wr", o_gpio, 32'h12345678);
        drive(16'h9000, 32'hFFFFFFFF);
        check("unmapped_wr", o_gpio, 32'h12345678);
        check_read("unmapped_rd", 16'h9000, 32'h0);

        // Counter load and wrap.
        drive(16'h8004, 32'hFFFFFFFE);
        check_read("cycle_ld", 16'h8004, 32'hFFFFFFFE);
        check_read("cycle_ld1", 16'h8004, 32'hFFFFFFFF);
        check_read("cycle_wrap", 16'h8004, 32'h00000000);

        // FIFO fill, overflow, clear, drain.
        i_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(16'h8008, 32'h41 + i);
        check_read("stat_full", 16'h800C, 32'h22);
        drive(16'h8008, 32'h45);
        check_read("stat_ovf", 16'h800C, 32'h26);
        drive(16'h800C, 32'h4);
        check_read("stat_clr", 16'h800C, 32'h22);
        i_address  = 16'h0000;
        i_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_stream("drain", 8'(8'h41 + i));
        check("drain_done", 32'(o_tx_valid), 32'h0);
        check_read("stat_empty", 16'h800C, 32'h01);

        // Push into a full FIFO with a same-cycle pop.
        i_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(16'h8008, 32'h61 + i);
        i_tx_ready = 1'b1;
        drive(16'h8008, 32'h55);
        i_tx_ready = 1'b0;
        check_read("stat_pushpop", 16'h800C, 32'h22);
        i_tx_ready = 1'b1;
        expect_stream("pp1", 8'h62);
        expect_stream("pp2", 8'h63);
        expect_stream("pp3", 8'h64);
        expect_stream("pp4", 8'h55);
        check("pp_done", 32'(o_tx_valid), 32'h0);

        // Push into an empty FIFO: valid rises one cycle later.
        i_tx_ready = 1'b0;
        i_address  = 16'h8008;
        i_data     = 32'h77;
        i_rw       = 1'b1;
        #1;
        check("nobypass", 32'(o_tx_valid), 32'h0);
        @(posedge i_clk); #1;
        i_rw = 1'b0;
        expect_stream("after_push", 8'h77);
        i_tx_ready = 1'b1;
        @(posedge i_clk); #1;
        i_tx_ready = 1'b0;
        check("popped", 32'(o_tx_valid), 32'h0);

        // Asynchronous reset in the middle of activity.
        drive(16'h8000, 32'hFF);
        drive(16'h8004, 32'd98);
        for (int i = 0; i < 3; i++) drive(16'h8008, 32'hA1 + i);
        check("pre_rst_valid", 32'(o_tx_valid), 32'h1);
        #3 i_reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_tx_valid), 32'h0);
        check("arst_gpio", o_gpio, 32'h0);
        check("arst_tx_data", 32'(o_tx_data), 32'h0);
        i_address = 16'h8004;
        #1;
        check("arst_cycle", o_data, 32'h0);
        i_address = 16'h800C;
        #1;
        check("arst_stat", o_data, 32'h01);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Randomized traffic with varying sink back-pressure.
        for (int blk = 0; blk < 6; blk++) begin
            pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 400; c++) begin
                i_address  = pick_addr();
                i_rw       = 1'($urandom_range(0, 1));
                i_data     = $urandom;
                i_tx_ready = ($urandom_range(0, 99) < pct);
                @(posedge i_clk); #1;
            end
        end

        // Drain with the bus idle.
        i_rw       = 1'b0;
        i_address  = 16'h800C;
        i_tx_ready = 1'b1;
        repeat (DEPTH + 2) begin
            @(posedge i_clk); #1;
        end
        check("final_empty", 32'(o_tx_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
